// File: rtl/sparc_pc_npc_unit.sv
// rtl/sparc_pc_npc_unit.sv - SPARC fetch-stage PC/nPC sequencer with delayed control transfer
// Handles trap redirect, JMPL/CALL/Bicc targets, annulled delay slots, stall and boot.
module sparc_pc_npc_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_BYTES = 4,
  parameter bit                ANNUL_EN    = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              LE,
  input  logic              trap_valid,
  input  logic [ADDR_W-1:0] trap_vec,
  input  logic              jmpl_valid,
  input  logic [ADDR_W-1:0] alu_target,
  input  logic              call_valid,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic              br_always,
  input  logic              br_annul,
  input  logic [ADDR_W-1:0] ta,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic              pc_valid,
  output logic              annul_slot,
  output logic              misalign
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = STEP - 1'b1;

  typedef enum logic [1:0] {BOOT, RUN, ANNUL} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, npc_q, pc_nxt, npc_nxt;
  logic              misalign_q, misalign_nxt;
  logic [ADDR_W-1:0] seq_npc;
  logic              br_take, annul_br;

  assign seq_npc  = npc_q + STEP;
  assign br_take  = br_valid & (br_taken | br_always);
  // Slot squashed when a=1 and the branch is either BA or not taken.
  assign annul_br = ANNUL_EN & br_valid & br_annul & (br_always | ~br_taken);

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr & ALIGN_MASK) != '0;
  endfunction

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    npc_nxt      = npc_q;
    misalign_nxt = 1'b0;
    if (LE) begin
      case (state)
        BOOT: state_nxt = RUN;
        RUN: begin
          if (trap_valid) begin
            if (is_misaligned(trap_vec)) begin
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt  = trap_vec;
              npc_nxt = trap_vec + STEP;
            end
          end else if (jmpl_valid) begin
            if (is_misaligned(alu_target)) begin
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt  = npc_q;
              npc_nxt = alu_target;
            end
          end else if (call_valid || br_take) begin
            if (is_misaligned(ta)) begin
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt    = npc_q;
              npc_nxt   = ta;
              state_nxt = (!call_valid && annul_br) ? ANNUL : RUN;
            end
          end else begin
            pc_nxt    = npc_q;
            npc_nxt   = seq_npc;
            state_nxt = annul_br ? ANNUL : RUN;
          end
        end
        ANNUL: begin
          // A squashed instruction may not redirect; only a trap can.
          if (trap_valid) begin
            if (is_misaligned(trap_vec)) begin
              misalign_nxt = 1'b1;
            end else begin
              pc_nxt    = trap_vec;
              npc_nxt   = trap_vec + STEP;
              state_nxt = RUN;
            end
          end else begin
            pc_nxt    = npc_q;
            npc_nxt   = seq_npc;
            state_nxt = RUN;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      npc_q      <= RESET_PC + STEP;
      misalign_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      npc_q      <= npc_nxt;
      misalign_q <= misalign_nxt;
    end
  end

  assign pc         = pc_q;
  assign npc        = npc_q;
  assign pc_valid   = (state != BOOT);
  assign annul_slot = (state == ANNUL);
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_sparc_pc_npc_unit.sv
// tb/tb_sparc_pc_npc_unit.sv - directed scoreboard bench for sparc_pc_npc_unit
module tb_sparc_pc_npc_unit;

  logic        clk = 1'b0;
  logic        clr, LE;
  logic        trap_valid, jmpl_valid, call_valid;
  logic        br_valid, br_taken, br_always, br_annul;
  logic [31:0] trap_vec, alu_target, ta;
  logic [31:0] pc, npc;
  logic        pc_valid, annul_slot, misalign;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        v;
    logic        a;
    logic        m;
  } exp_t;

  exp_t sb[$];

  sparc_pc_npc_unit #(
    .ADDR_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4), .ANNUL_EN(1'b1)
  ) dut (
    .clk(clk), .clr(clr), .LE(LE),
    .trap_valid(trap_valid), .trap_vec(trap_vec),
    .jmpl_valid(jmpl_valid), .alu_target(alu_target),
    .call_valid(call_valid),
    .br_valid(br_valid), .br_taken(br_taken), .br_always(br_always), .br_annul(br_annul),
    .ta(ta),
    .pc(pc), .npc(npc), .pc_valid(pc_valid), .annul_slot(annul_slot), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expectation, clock once, then pop and compare after the edge.
  task automatic step(input string tag, input logic [31:0] e_pc, input logic [31:0] e_npc,
                      input logic e_v, input logic e_a, input logic e_m);
    exp_t e;
    sb.push_back('{tag, e_pc, e_npc, e_v, e_a, e_m});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"}, pc, e.pc);
    chk({e.tag, ".npc"}, npc, e.npc);
    chk({e.tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, e.v});
    chk({e.tag, ".annul_slot"}, {31'b0, annul_slot}, {31'b0, e.a});
    chk({e.tag, ".misalign"}, {31'b0, misalign}, {31'b0, e.m});
  endtask

  task automatic idle();
    LE = 1'b1;
    trap_valid = 0; jmpl_valid = 0; call_valid = 0;
    br_valid = 0; br_taken = 0; br_always = 0; br_annul = 0;
    trap_vec = '0; alu_target = '0; ta = '0;
  endtask

  initial begin
    clr = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) step("reset", 32'h0, 32'h4, 0, 0, 0);
    clr = 1'b1;
    step("boot_exit", 32'h0, 32'h4, 1, 0, 0);
    step("seq4", 32'h4, 32'h8, 1, 0, 0);
    step("seq8", 32'h8, 32'hC, 1, 0, 0);
    step("seq12", 32'hC, 32'h10, 1, 0, 0);
    step("seq16", 32'h10, 32'h14, 1, 0, 0);

    br_valid = 1; br_taken = 1; ta = 32'h100;
    step("br_taken_slot", 32'h14, 32'h100, 1, 0, 0);
    idle();
    step("br_target", 32'h100, 32'h104, 1, 0, 0);

    trap_valid = 1; trap_vec = 32'h1C;
    step("trap_1c", 32'h1C, 32'h20, 1, 0, 0);
    idle();
    step("seq20", 32'h20, 32'h24, 1, 0, 0);
    br_valid = 1; br_always = 1; br_annul = 1; ta = 32'h200;
    step("ba_annul", 32'h24, 32'h200, 1, 1, 0);
    idle();
    call_valid = 1; ta = 32'h300;
    step("annul_ignores_call", 32'h200, 32'h204, 1, 0, 0);

    idle();
    trap_valid = 1; trap_vec = 32'h20;
    step("trap_20", 32'h20, 32'h24, 1, 0, 0);
    idle();
    br_valid = 1; br_annul = 1;
    step("nt_annul", 32'h24, 32'h28, 1, 1, 0);
    idle();
    step("after_nt_annul", 32'h28, 32'h2C, 1, 0, 0);
    br_valid = 1; br_taken = 1; br_annul = 1; ta = 32'h400;
    step("taken_cond_a1", 32'h2C, 32'h400, 1, 0, 0);
    idle();
    step("taken_cond_tgt", 32'h400, 32'h404, 1, 0, 0);

    trap_valid = 1; trap_vec = 32'h80; jmpl_valid = 1; alu_target = 32'h900;
    call_valid = 1; ta = 32'hA00;
    step("prio_trap", 32'h80, 32'h84, 1, 0, 0);
    idle();
    jmpl_valid = 1; alu_target = 32'h500; call_valid = 1; ta = 32'h600;
    step("prio_jmpl", 32'h84, 32'h500, 1, 0, 0);
    idle();
    step("jmpl_tgt", 32'h500, 32'h504, 1, 0, 0);

    for (int i = 0; i < 4; i++) begin
      LE = 1'b0;
      trap_valid = 1'($urandom); jmpl_valid = 1'($urandom); call_valid = 1'($urandom);
      br_valid = 1'($urandom); br_taken = 1'($urandom); br_always = 1'($urandom);
      br_annul = 1'($urandom);
      trap_vec = $urandom; alu_target = $urandom; ta = $urandom;
      step("stall", 32'h500, 32'h504, 1, 0, 0);
    end
    idle();

    jmpl_valid = 1; alu_target = 32'h102;
    step("misalign_jmpl", 32'h500, 32'h504, 1, 0, 1);
    idle();
    step("misalign_clear", 32'h504, 32'h508, 1, 0, 0);
    trap_valid = 1; trap_vec = 32'h81;
    step("misalign_trap", 32'h504, 32'h508, 1, 0, 1);
    idle();

    trap_valid = 1; trap_vec = 32'hFFFF_FFF8;
    step("trap_high", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1, 0, 0);
    idle();
    step("wrap_npc", 32'hFFFF_FFFC, 32'h0, 1, 0, 0);
    step("wrap_pc", 32'h0, 32'h4, 1, 0, 0);

    br_valid = 1; br_annul = 1;
    step("annul_at_0", 32'h4, 32'h8, 1, 1, 0);
    idle();
    trap_valid = 1; trap_vec = 32'h40; jmpl_valid = 1; alu_target = 32'h700;
    step("trap_in_annul", 32'h40, 32'h44, 1, 0, 0);
    idle();
    br_valid = 1; br_annul = 1;
    step("annul_again", 32'h44, 32'h48, 1, 1, 0);
    idle();
    clr = 1'b0;
    step("reset_in_annul", 32'h0, 32'h4, 0, 0, 0);
    clr = 1'b1; LE = 1'b0;
    step("boot_stall", 32'h0, 32'h4, 0, 0, 0);
    LE = 1'b1;
    step("boot_exit2", 32'h0, 32'h4, 1, 0, 0);
    step("seq_after_boot", 32'h4, 32'h8, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sparc_pc_npc_unit.md
Name: sparc_pc_npc_unit

Overview:
- Parametrised PC/nPC sequencer for the SPARC fetch stage.
- Replaces the separate PC register, nPC register, +4 adder and select logic with one block.
- Implements SPARC delayed control transfer (DCTI), including the annul bit, trap redirect, target alignment checking, a stall hold and a boot state.
- Feeds instruction-memory address and a delay-slot squash flag to IF/ID.

Parameters:
ADDR_W, 32, width of PC/nPC and all target inputs
RESET_PC, 0, PC value loaded on reset; nPC resets to RESET_PC+INSTR_BYTES
INSTR_BYTES, 4, sequential increment; power of two ≥1; alignment checks use low log2(INSTR_BYTES) bits
ANNUL_EN, 1, 0 = annul input ignored, annul_slot never asserts

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous reset, ACTIVE-LOW (clr=0 at posedge resets)
LE  in  1  load enable; 0 = stall, all state holds
trap_valid  in  1  trap/interrupt redirect request
trap_vec  in  ADDR_W  trap handler address
jmpl_valid  in  1  JMPL decoded in ID
alu_target  in  ADDR_W  JMPL target from ALU
call_valid  in  1  CALL decoded in ID
br_valid  in  1  Bicc decoded in ID
br_taken  in  1  condition evaluated true (qualified by br_valid)
br_always  in  1  branch is BA (qualified by br_valid)
br_annul  in  1  instruction a-bit (qualified by br_valid)
ta  in  ADDR_W  CALL/branch target address
pc  out  ADDR_W  current PC (fetch address)
npc  out  ADDR_W  next PC
pc_valid  out  1  PC is a real fetch (low in reset/boot)
annul_slot  out  1  instruction at pc is annulled; ID must squash it
misalign  out  1  one-cycle pulse: selected redirect target misaligned

Behaviour:
- One clock, synchronous active-low reset. All updates occur at posedge clk.
- While clr=0: pc=RESET_PC, npc=RESET_PC+INSTR_BYTES, pc_valid=0, annul_slot=0, misalign=0, state=BOOT. Reset has priority over LE and wins mid-operation; no pending redirect survives it.
- FSM states: BOOT, RUN, ANNUL.
  - BOOT: first posedge with clr=1 and LE=1 moves to RUN. PC/nPC are not advanced and all control inputs are ignored.
  - pc_valid=1 in RUN and ANNUL. annul_slot=1 only in ANNUL.
- LE=0 with clr=1: pc, npc, state and annul_slot hold, inputs are ignored, and misalign is driven 0.
- In RUN with LE=1, the redirect source is chosen by fixed priority:
  1. trap_valid: pc<=trap_vec, npc<=trap_vec+INSTR_BYTES. This is not delayed and leads to RUN. It is the only redirect also honoured in ANNUL.
  2. jmpl_valid: pc<=npc, npc<=alu_target.
  3. call_valid: pc<=npc, npc<=ta.
  4. br_valid&(br_taken|br_always): pc<=npc, npc<=ta.
  5. Otherwise: pc<=npc, npc<=npc+INSTR_BYTES.
- Annul, applied with ANNUL_EN=1 and br_valid=1: the next state is ANNUL when br_annul=1 and either br_always=1 (taken, slot squashed) or the branch is not taken. A taken conditional branch with a=1 executes its slot and goes to RUN. In all other cases the next state is RUN.
- In ANNUL with LE=1:
  - jmpl/call/br inputs are ignored, because a squashed instruction may not redirect.
  - The sequential update pc<=npc, npc<=npc+INSTR_BYTES is applied, then the state returns to RUN.
  - trap_valid still applies priority 1.
- DCTI couple (CTI in the delay slot of a taken CTI) follows the normal rules: pc<=old target, npc<=new target.
- Alignment: if the selected redirect target (trap_vec, alu_target or ta) has nonzero low log2(INSTR_BYTES) bits:
  - misalign=1 for that cycle, registered and visible the following cycle for one cycle.
  - pc, npc and state hold.
  - The sequential path never checks alignment.
- Arithmetic: all additions are modulo 2^ADDR_W, and wrap silently (e.g. npc=0xFFFFFFFC → 0x00000000).
- Latency: inputs sampled at edge N are reflected on pc/npc after edge N. There is no combinational input→output path.

Test Plan:
- Reset/boot: clr=0 for 3 cycles, then clr=1, LE=1 → pc=0, npc=4, pc_valid=0 in boot cycle; next edge pc_valid=1, pc=0; following edges pc=4, 8, 12.
- Taken branch with delay slot: at pc=0x10 (npc=0x14), br_valid=1, br_taken=1, ta=0x100 → pc=0x14, npc=0x100, annul_slot=0; next edge pc=0x100, npc=0x104.
- Annul cases:
  - br_always=1, br_annul=1, ta=0x200 at pc=0x20 → next pc=0x24 with annul_slot=1. A call_valid asserted that cycle is ignored. Then pc=0x200.
  - Not-taken with a=1 → slot 0x24 annulled, then pc=0x28.
- Priority/stall: trap_valid, jmpl_valid and call_valid asserted together with trap_vec=0x80 → pc=0x80, npc=0x84. LE=0 for 4 cycles with random inputs → pc/npc unchanged.
- Misalign: jmpl_valid=1, alu_target=0x102 → misalign pulses for one cycle, pc/npc unchanged.
- Wrap: with pc=0xFFFFFFF8 → pc=0xFFFFFFFC, npc=0x0, then pc=0x0. Reset asserted while in ANNUL → pc=RESET_PC, annul_slot=0.
